// File: rtl/mem_stage_pkg.sv
// Shared widths, bus payload layouts and extension helpers for the MEM stage.
package mem_stage_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD = 113;
    localparam int unsigned MS_TO_WS_BUS_WD = 73;
    localparam int unsigned STALL_BUS_WD    = 10;
    localparam int unsigned FORWARD_BUS_WD  = 33;
    localparam int unsigned LOAD_OP_WD      = 7;

    // One-hot load_op bit positions, MSB first: lb,lbu,lh,lhu,lw,lwl,lwr
    localparam int unsigned LD_LB  = 6;
    localparam int unsigned LD_LBU = 5;
    localparam int unsigned LD_LH  = 4;
    localparam int unsigned LD_LHU = 3;
    localparam int unsigned LD_LW  = 2;
    localparam int unsigned LD_LWL = 1;
    localparam int unsigned LD_LWR = 0;

    typedef struct packed {
        logic [LOAD_OP_WD-1:0] load_op;
        logic                  mem_req;
        logic [3:0]            gr_we;
        logic [4:0]            dest;
        logic [31:0]           alu_result;
        logic [31:0]           rt_value;
        logic [31:0]           pc;
    } es_to_ms_t;

    // Instruction fields kept while resident in MEM (mem_req only steers the FSM)
    typedef struct packed {
        logic [LOAD_OP_WD-1:0] load_op;
        logic [3:0]            gr_we;
        logic [4:0]            dest;
        logic [31:0]           alu_result;
        logic [31:0]           rt_value;
        logic [31:0]           pc;
    } ms_entry_t;

    typedef struct packed {
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: byte/half select with extension, and LWL/LWR merge with rt.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [LOAD_OP_WD-1:0] load_op,
    input  logic [1:0]            addr_lo,
    input  logic [31:0]           rdata,
    input  logic [31:0]           rt_value,
    input  logic [31:0]           alu_result,
    output logic [31:0]           result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lwl_val;
    logic [31:0] lwr_val;

    always_comb begin
        byte_sel = rdata[7:0];
        lwl_val  = rdata;
        lwr_val  = rdata;
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        unique case (addr_lo)
            2'd0: begin
                byte_sel = rdata[7:0];
                lwl_val  = {rdata[7:0], rt_value[23:0]};
                lwr_val  = rdata;
            end
            2'd1: begin
                byte_sel = rdata[15:8];
                lwl_val  = {rdata[15:0], rt_value[15:0]};
                lwr_val  = {rt_value[31:24], rdata[31:8]};
            end
            2'd2: begin
                byte_sel = rdata[23:16];
                lwl_val  = {rdata[23:0], rt_value[7:0]};
                lwr_val  = {rt_value[31:16], rdata[31:16]};
            end
            default: begin
                byte_sel = rdata[31:24];
                lwl_val  = rdata;
                lwr_val  = {rt_value[31:8], rdata[31:24]};
            end
        endcase
    end

    always_comb begin
        result = alu_result;
        if (load_op[LD_LB])       result = ext8(byte_sel, 1'b1);
        else if (load_op[LD_LBU]) result = ext8(byte_sel, 1'b0);
        else if (load_op[LD_LH])  result = ext16(half_sel, 1'b1);
        else if (load_op[LD_LHU]) result = ext16(half_sel, 1'b0);
        else if (load_op[LD_LW])  result = rdata;
        else if (load_op[LD_LWL]) result = lwl_val;
        else if (load_op[LD_LWR]) result = lwr_val;
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, buffers returned load data, and
// drives the MS->WS, stall and forward buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
    output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q;
    logic        ms_valid_q;
    ms_entry_t   entry_q;
    logic [31:0] rdata_q;

    es_to_ms_t   es_in;
    ms_to_ws_t   ws_out;
    logic        ms_ready_go;
    logic        accept;
    logic [31:0] final_result;

    assign es_in       = es_to_ms_t'(es_to_ms_bus);
    assign ms_ready_go = (state_q == S_DONE);
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign accept      = es_to_ms_valid && ms_allowin;

    // Returned data is only ever taken from the buffer, so the result stays put under WB stall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            ms_valid_q <= 1'b0;
            entry_q    <= '0;
            rdata_q    <= '0;
        end else if (accept) begin
            entry_q.load_op    <= es_in.load_op;
            entry_q.gr_we      <= es_in.gr_we;
            entry_q.dest       <= es_in.dest;
            entry_q.alu_result <= es_in.alu_result;
            entry_q.rt_value   <= es_in.rt_value;
            entry_q.pc         <= es_in.pc;
            ms_valid_q         <= 1'b1;
            state_q            <= es_in.mem_req ? S_WAIT : S_DONE;
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    if (data_sram_data_ok) begin
                        rdata_q <= data_sram_rdata;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ws_allowin) begin
                        ms_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    ms_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    mem_load_align u_align (
        .load_op    (entry_q.load_op),
        .addr_lo    (entry_q.alu_result[1:0]),
        .rdata      (rdata_q),
        .rt_value   (entry_q.rt_value),
        .alu_result (entry_q.alu_result),
        .result     (final_result)
    );

    always_comb begin
        ws_out.gr_we        = entry_q.gr_we;
        ws_out.dest         = entry_q.dest;
        ws_out.final_result = final_result;
        ws_out.pc           = entry_q.pc;
    end

    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign ms_to_ws_bus   = ws_out;
    assign stall_ms_bus   = {ms_valid_q && (|entry_q.gr_we),
                             {4{ms_valid_q}} & entry_q.gr_we,
                             entry_q.dest};
    assign forward_ms_bus = {ms_valid_q && ms_ready_go, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic against a behavioural model.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [112:0] es_to_ms_bus;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [72:0]  ms_to_ws_bus;
    logic         data_ok;
    logic [31:0]  rdata;
    logic [9:0]   stall_ms_bus;
    logic [32:0]  forward_ms_bus;

    // Stimulus fields
    logic [6:0]  in_op;
    logic        in_req;
    logic [3:0]  in_we;
    logic [4:0]  in_dest;
    logic [31:0] in_alu, in_rt, in_pc;

    assign es_to_ms_bus = {in_op, in_req, in_we, in_dest, in_alu, in_rt, in_pc};

    // Model: what instruction sits in MEM and whether its data has arrived
    logic        m_valid, m_req, m_got;
    logic [6:0]  m_op;
    logic [3:0]  m_we;
    logic [4:0]  m_dest;
    logic [31:0] m_alu, m_rt, m_pc, m_r;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] OP_LB  = 7'b1000000;
    localparam logic [6:0] OP_LBU = 7'b0100000;
    localparam logic [6:0] OP_LW  = 7'b0000100;
    localparam logic [6:0] OP_LWL = 7'b0000010;
    localparam logic [6:0] OP_LWR = 7'b0000001;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .stall_ms_bus      (stall_ms_bus),
        .forward_ms_bus    (forward_ms_bus)
    );

    always #5 clk = ~clk;

    // Expected result from the ISA rules, using shifts and masks on whole words
    function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [31:0] alu,
                                               input logic [31:0] rt, input logic [31:0] r);
        int unsigned a;
        logic [31:0] w;
        logic [63:0] mask;
        a = int'(alu[1:0]);
        case (op)
            7'b1000000, 7'b0100000: begin
                w = (r >> (8 * a)) & 32'hFF;
                if (op[6] && w[7]) w = w | 32'hFFFF_FF00;
                return w;
            end
            7'b0010000, 7'b0001000: begin
                w = (r >> (16 * (a / 2))) & 32'hFFFF;
                if (op[4] && w[15]) w = w | 32'hFFFF_0000;
                return w;
            end
            7'b0000100: return r;
            7'b0000010: begin
                mask = 64'hFFFF_FFFF >> (8 * (a + 1));
                return (r << (8 * (3 - a))) | (rt & mask[31:0]);
            end
            7'b0000001: begin
                mask = 64'hFFFF_FFFF >> (8 * a);
                return (r >> (8 * a)) | (rt & ~mask[31:0]);
            end
            default: return alu;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_req = 1'b0; m_got = 1'b0;
        m_op = '0; m_we = '0; m_dest = '0;
        m_alu = '0; m_rt = '0; m_pc = '0; m_r = '0;
    endtask

    // Compare every observable output against the model
    task automatic check_outputs();
        logic        rdy;
        logic [31:0] res;
        rdy = m_valid && (!m_req || m_got);
        res = ref_result(m_op, m_alu, m_rt, m_r);
        chk("allowin", 128'(ms_allowin), 128'(!m_valid || (rdy && ws_allowin)));
        chk("ws_valid", 128'(ms_to_ws_valid), 128'(rdy));
        if (rdy) begin
            chk("ws_bus", 128'(ms_to_ws_bus), 128'({m_we, m_dest, res, m_pc}));
            chk("fwd_bus", 128'(forward_ms_bus), 128'({1'b1, res}));
        end else begin
            chk("fwd_valid", 128'(forward_ms_bus[32]), 128'(1'b0));
        end
        chk("stall_we", 128'(stall_ms_bus[9:5]), 128'({m_valid && (|m_we), {4{m_valid}} & m_we}));
        if (m_valid) chk("stall_dest", 128'(stall_ms_bus[4:0]), 128'(m_dest));
    endtask

    task automatic model_update();
        logic rdy, acc;
        rdy = m_valid && (!m_req || m_got);
        acc = es_to_ms_valid && (!m_valid || (rdy && ws_allowin));
        if (acc) begin
            m_valid = 1'b1; m_req = in_req; m_got = 1'b0;
            m_op = in_op; m_we = in_we; m_dest = in_dest;
            m_alu = in_alu; m_rt = in_rt; m_pc = in_pc;
        end else if (m_valid && m_req && !m_got) begin
            if (data_ok) begin
                m_got = 1'b1;
                m_r   = rdata;
            end
        end else if (rdy && ws_allowin) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic req, input logic [3:0] we,
                         input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] rt);
        es_to_ms_valid = v;
        in_op = op; in_req = req; in_we = we; in_dest = dst;
        in_alu = alu; in_rt = rt; in_pc = 32'hBFC0_0000 + alu;
    endtask

    // Issue a load, leave it waiting 'gap' cycles, return data, and check the result literally
    task automatic run_load(input string name, input logic [6:0] op, input logic [31:0] alu,
                            input logic [31:0] rt, input logic [31:0] rd, input int gap,
                            input logic [31:0] want);
        ws_allowin = 1'b1;
        data_ok = 1'b0;
        drive(1'b1, op, 1'b1, 4'hF, 5'd9, alu, rt);
        step();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < gap; i++) step();
        data_ok = 1'b1;
        rdata = rd;
        step();
        data_ok = 1'b0;
        rdata = 32'h0;
        #1;
        chk({name, "_valid"}, 128'(ms_to_ws_valid), 128'(1'b1));
        chk({name, "_result"}, 128'(ms_to_ws_bus[63:32]), 128'(want));
        step();
    endtask

    initial begin
        resetn = 1'b0;
        ws_allowin = 1'b0;
        data_ok = 1'b0;
        rdata = '0;
        drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
        model_reset();
        #12;
        chk("rst_allowin", 128'(ms_allowin), 128'(1'b1));
        chk("rst_ws_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        chk("rst_ws_bus", 128'(ms_to_ws_bus), 128'(0));
        chk("rst_stall", 128'(stall_ms_bus), 128'(0));
        chk("rst_fwd", 128'(forward_ms_bus), 128'(0));
        @(negedge clk);
        resetn = 1'b1;

        // Non-load: result visible the cycle after acceptance
        ws_allowin = 1'b1;
        drive(1'b1, '0, 1'b0, 4'hF, 5'd3, 32'h0000_1234, 32'h0);
        step();
        es_to_ms_valid = 1'b0;
        #1;
        chk("add_valid", 128'(ms_to_ws_valid), 128'(1'b1));
        chk("add_result", 128'(ms_to_ws_bus[63:32]), 128'(32'h0000_1234));
        step();

        run_load("lb", OP_LB, 32'h1000_0003, 32'h0, 32'h80FF_0000, 2, 32'hFFFF_FF80);
        run_load("lbu", OP_LBU, 32'h1000_0003, 32'h0, 32'h80FF_0000, 2, 32'h0000_0080);
        run_load("lwl", OP_LWL, 32'h1000_0001, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'hCCDD_3344);
        run_load("lwr", OP_LWR, 32'h1000_0002, 32'h1122_3344, 32'hAABB_CCDD, 0, 32'h1122_AABB);

        // WB stalls after the load completes; changing rdata must not leak through
        ws_allowin = 1'b0;
        drive(1'b1, OP_LW, 1'b1, 4'hF, 5'd7, 32'h2000_0000, 32'h0);
        step();
        es_to_ms_valid = 1'b0;
        data_ok = 1'b1;
        rdata = 32'hDEAD_BEEF;
        step();
        for (int i = 0; i < 3; i++) begin
            data_ok = 1'b1;
            rdata = $urandom;
            #1;
            chk("hold_allowin", 128'(ms_allowin), 128'(1'b0));
            chk("hold_result", 128'(ms_to_ws_bus[63:32]), 128'(32'hDEAD_BEEF));
            step();
        end
        data_ok = 1'b0;
        ws_allowin = 1'b1;
        step();

        // Back-to-back ALU ops, one handed off per cycle
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, '0, 1'b0, 4'hF, 5'(i + 1), 32'(i * 256 + 16), 32'h0);
            #1;
            if (i > 0) begin
                chk("b2b_allowin", 128'(ms_allowin), 128'(1'b1));
                chk("b2b_stall_dest", 128'(stall_ms_bus[4:0]), 128'(5'(i)));
                chk("b2b_fwd", 128'(forward_ms_bus), 128'({1'b1, 32'((i - 1) * 256 + 16)}));
            end
            step();
        end

        // Reset while a load is waiting; a late data_ok must be ignored
        drive(1'b1, OP_LW, 1'b1, 4'hF, 5'd12, 32'h3000_0000, 32'h0);
        step();
        es_to_ms_valid = 1'b0;
        step();
        resetn = 1'b0;
        model_reset();
        #1;
        chk("rstw_ws_valid", 128'(ms_to_ws_valid), 128'(1'b0));
        chk("rstw_allowin", 128'(ms_allowin), 128'(1'b1));
        chk("rstw_stall", 128'(stall_ms_bus), 128'(0));
        @(negedge clk);
        resetn = 1'b1;
        data_ok = 1'b1;
        rdata = 32'h5555_AAAA;
        step();
        data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rstw_idle", 128'(ms_to_ws_valid), 128'(1'b0));
            step();
        end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned sel;
            sel = $urandom_range(0, 8);
            es_to_ms_valid = ($urandom_range(0, 2) != 0);
            in_op   = (sel < 7) ? 7'(7'b1000000 >> sel) : 7'b0;
            in_req  = (sel < 8);
            in_we   = 4'($urandom);
            in_dest = 5'($urandom);
            in_alu  = $urandom;
            in_rt   = $urandom;
            in_pc   = $urandom;
            ws_allowin = ($urandom_range(0, 3) != 0);
            data_ok = ($urandom_range(0, 2) == 0);
            rdata   = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
